// File: rtl/valid_stretch_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : valid_stretch_mc
// Description : Multi-channel valid-window generator. A trigger on a channel
//               opens an o_valid window exactly cfg_len clocks long, with
//               optional retrigger extension, post-window holdoff, edge or
//               level triggering, synchronous clear and a per-channel done
//               pulse on the last high cycle of a completed window.
// Revision    : 1.0 - initial release
// ============================================================================
module valid_stretch_mc #(
    parameter int NUM_CH    = 4,
    parameter int LEN_W     = 10,
    parameter int HOLDOFF   = 0,
    parameter int EDGE_TRIG = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_retrig,
    input  logic              i_clear,
    input  logic [NUM_CH-1:0] i_valid,
    output logic [NUM_CH-1:0] o_valid,
    output logic [NUM_CH-1:0] o_done,
    output logic              o_busy
);

    localparam logic [1:0]       c_idle    = 2'd0;
    localparam logic [1:0]       c_active  = 2'd1;
    localparam logic [1:0]       c_hold    = 2'd2;
    localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_hold_m1 = (HOLDOFF > 0) ? LEN_W'(HOLDOFF - 1) : '0;

    logic [1:0]        state_q [NUM_CH];
    logic [1:0]        state_d [NUM_CH];
    logic [LEN_W-1:0]  cnt_q   [NUM_CH];
    logic [LEN_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] prev_d;
    logic [NUM_CH-1:0] valid_q;
    logic [NUM_CH-1:0] valid_d;
    logic              busy_q;
    logic              busy_d;

    logic              w_len_nz;
    logic [NUM_CH-1:0] w_trig;
    logic [NUM_CH-1:0] w_reload;

    // Qualify triggers: edge/level selection and window-extension requests
    always_comb begin
        w_len_nz = |cfg_len;
        w_trig   = (EDGE_TRIG != 0) ? (i_valid & ~prev_q) : i_valid;
        w_reload = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_reload[ch] = cfg_retrig & w_trig[ch] & w_len_nz & (state_q[ch] == c_active);
        end
    end

    // State register: per-channel FSM state, counters, edge history, outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= c_idle;
                cnt_q[ch]   <= '0;
            end
            prev_q  <= '0;
            valid_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            prev_q  <= prev_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: clear wins over everything, then per-state transitions
    always_comb begin
        // Edge history keeps tracking the input even while clearing
        prev_d = i_valid;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            if (i_clear) begin
                state_d[ch] = c_idle;
                cnt_d[ch]   = '0;
            end else begin
                case (state_q[ch])
                    c_idle: begin
                        if (w_trig[ch] && w_len_nz) begin
                            state_d[ch] = c_active;
                            cnt_d[ch]   = cfg_len - c_one;
                        end
                    end
                    c_active: begin
                        if (w_reload[ch]) begin
                            cnt_d[ch] = cfg_len - c_one;
                        end else if (cnt_q[ch] == '0) begin
                            if (HOLDOFF > 0) begin
                                state_d[ch] = c_hold;
                                cnt_d[ch]   = c_hold_m1;
                            end else begin
                                state_d[ch] = c_idle;
                                cnt_d[ch]   = '0;
                            end
                        end else begin
                            cnt_d[ch] = cnt_q[ch] - c_one;
                        end
                    end
                    c_hold: begin
                        if (cnt_q[ch] == '0) begin
                            state_d[ch] = c_idle;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] - c_one;
                        end
                    end
                    default: begin
                        state_d[ch] = c_idle;
                        cnt_d[ch]   = '0;
                    end
                endcase
            end
        end
    end

    // Output logic: registered valid/busy follow next state; done is the
    // final cycle of a window that is neither extended nor aborted
    always_comb begin
        valid_d = '0;
        busy_d  = 1'b0;
        o_done  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            valid_d[ch] = (state_d[ch] == c_active);
            busy_d      = busy_d | (state_d[ch] != c_idle);
            o_done[ch]  = (state_q[ch] == c_active) && (cnt_q[ch] == '0)
                          && !i_clear && !w_reload[ch];
        end
    end

    assign o_valid = valid_q;
    assign o_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_valid_stretch_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_valid_stretch_mc
// Description : Directed self-checking bench for valid_stretch_mc. Three
//               instances cover level/no-holdoff, level/holdoff and edge mode.
//               Cycle k is the clock period ending at edge k; a trigger
//               sampled at edge k opens a window over cycles k+1..k+len.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_valid_stretch_mc;

    logic clk;
    logic reset_n;

    // Instance A: 4 channels, level, no holdoff
    logic [9:0] a_len;
    logic       a_retrig;
    logic       a_clear;
    logic [3:0] a_in;
    logic [3:0] a_valid;
    logic [3:0] a_done;
    logic       a_busy;

    // Instance H: 2 channels, level, HOLDOFF=3
    logic [9:0] h_len;
    logic [1:0] h_in;
    logic [1:0] h_valid;
    logic [1:0] h_done;
    logic       h_busy;

    // Instance E: 2 channels, edge triggered
    logic [9:0] e_len;
    logic [1:0] e_in;
    logic [1:0] e_valid;
    logic [1:0] e_done;
    logic       e_busy;

    int n_cmp;
    int n_err;

    logic [3:0] exp4;
    logic [1:0] exp2;
    logic       expb;

    valid_stretch_mc #(.NUM_CH(4), .LEN_W(10), .HOLDOFF(0), .EDGE_TRIG(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .cfg_len(a_len), .cfg_retrig(a_retrig),
        .i_clear(a_clear), .i_valid(a_in), .o_valid(a_valid), .o_done(a_done),
        .o_busy(a_busy)
    );

    valid_stretch_mc #(.NUM_CH(2), .LEN_W(10), .HOLDOFF(3), .EDGE_TRIG(0)) dut_h (
        .clk(clk), .reset_n(reset_n), .cfg_len(h_len), .cfg_retrig(1'b0),
        .i_clear(1'b0), .i_valid(h_in), .o_valid(h_valid), .o_done(h_done),
        .o_busy(h_busy)
    );

    valid_stretch_mc #(.NUM_CH(2), .LEN_W(10), .HOLDOFF(0), .EDGE_TRIG(1)) dut_e (
        .clk(clk), .reset_n(reset_n), .cfg_len(e_len), .cfg_retrig(1'b0),
        .i_clear(1'b0), .i_valid(e_in), .o_valid(e_valid), .o_done(e_done),
        .o_busy(e_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_len = 10'd5; a_retrig = 1'b0; a_clear = 1'b0; a_in = 4'b0000;
        h_len = 10'd4; h_in = 2'b00;
        e_len = 10'd3; e_in = 2'b00;
        #3;
        for (int r = 0; r < 2; r++) begin
            n_cmp++;
            if (a_valid !== 4'b0000 || a_done !== 4'b0000 || a_busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_a r=%0d got v=%b d=%b b=%b exp 0000/0000/0", r, a_valid, a_done, a_busy);
            end
            n_cmp++;
            if (h_valid !== 2'b00 || h_done !== 2'b00 || h_busy !== 1'b0 ||
                e_valid !== 2'b00 || e_done !== 2'b00 || e_busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_he r=%0d got h=%b/%b/%b e=%b/%b/%b exp all 0", r,
                         h_valid, h_done, h_busy, e_valid, e_done, e_busy);
            end
            tick();
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        a_len = 10'd5;
        for (int k = 0; k <= 7; k++) begin
            a_in = (k == 0) ? 4'b0001 : 4'b0000;
            #1;
            exp4 = (k >= 1 && k <= 5) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (a_valid !== exp4) begin
                n_err++;
                $display("FAIL basic_valid k=%0d got=%b exp=%b", k, a_valid, exp4);
            end
            exp4 = (k == 5) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (a_done !== exp4) begin
                n_err++;
                $display("FAIL basic_done k=%0d got=%b exp=%b", k, a_done, exp4);
            end
            expb = (k >= 1 && k <= 5);
            n_cmp++;
            if (a_busy !== expb) begin
                n_err++;
                $display("FAIL basic_busy k=%0d got=%b exp=%b", k, a_busy, expb);
            end
            tick();
        end
    endtask

    task automatic test_retrigger();
        a_len = 10'd6;
        for (int pass = 0; pass < 2; pass++) begin
            a_retrig = (pass == 0);
            for (int k = 0; k <= 12; k++) begin
                a_in = (k == 0 || k == 4) ? 4'b0001 : 4'b0000;
                #1;
                if (pass == 0) exp4 = (k >= 1 && k <= 10) ? 4'b0001 : 4'b0000;
                else           exp4 = (k >= 1 && k <= 6)  ? 4'b0001 : 4'b0000;
                n_cmp++;
                if (a_valid !== exp4) begin
                    n_err++;
                    $display("FAIL retrig_valid pass=%0d k=%0d got=%b exp=%b", pass, k, a_valid, exp4);
                end
                if (pass == 0) exp4 = (k == 10) ? 4'b0001 : 4'b0000;
                else           exp4 = (k == 6)  ? 4'b0001 : 4'b0000;
                n_cmp++;
                if (a_done !== exp4) begin
                    n_err++;
                    $display("FAIL retrig_done pass=%0d k=%0d got=%b exp=%b", pass, k, a_done, exp4);
                end
                tick();
            end
        end
        a_retrig = 1'b0;
    endtask

    task automatic test_level_holdoff();
        h_len = 10'd4;
        for (int k = 0; k <= 13; k++) begin
            h_in = 2'b10;
            #1;
            exp2 = ((k >= 1 && k <= 4) || (k >= 9 && k <= 12)) ? 2'b10 : 2'b00;
            n_cmp++;
            if (h_valid !== exp2) begin
                n_err++;
                $display("FAIL hold_valid k=%0d got=%b exp=%b", k, h_valid, exp2);
            end
            exp2 = (k == 4 || k == 12) ? 2'b10 : 2'b00;
            n_cmp++;
            if (h_done !== exp2) begin
                n_err++;
                $display("FAIL hold_done k=%0d got=%b exp=%b", k, h_done, exp2);
            end
            expb = (k >= 1 && k <= 7) || (k >= 9);
            n_cmp++;
            if (h_busy !== expb) begin
                n_err++;
                $display("FAIL hold_busy k=%0d got=%b exp=%b", k, h_busy, expb);
            end
            tick();
        end
        h_in = 2'b00;
    endtask

    task automatic test_edge();
        e_len = 10'd3;
        for (int k = 0; k <= 27; k++) begin
            e_in = (k <= 19 || k >= 22) ? 2'b01 : 2'b00;
            #1;
            exp2 = ((k >= 1 && k <= 3) || (k >= 23 && k <= 25)) ? 2'b01 : 2'b00;
            n_cmp++;
            if (e_valid !== exp2) begin
                n_err++;
                $display("FAIL edge_valid k=%0d got=%b exp=%b", k, e_valid, exp2);
            end
            exp2 = (k == 3 || k == 25) ? 2'b01 : 2'b00;
            n_cmp++;
            if (e_done !== exp2) begin
                n_err++;
                $display("FAIL edge_done k=%0d got=%b exp=%b", k, e_done, exp2);
            end
            tick();
        end
        e_in = 2'b00;
    endtask

    task automatic test_clear();
        // Abort in the third cycle of an 8-cycle window
        a_len = 10'd8;
        for (int k = 0; k <= 10; k++) begin
            a_in    = (k == 0) ? 4'b0001 : 4'b0000;
            a_clear = (k == 3);
            #1;
            exp4 = (k >= 1 && k <= 3) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (a_valid !== exp4 || a_done !== 4'b0000) begin
                n_err++;
                $display("FAIL clear_mid k=%0d got v=%b d=%b exp v=%b d=0000", k, a_valid, a_done, exp4);
            end
            tick();
        end
        // Clear together with a trigger drops the trigger
        a_len = 10'd5;
        for (int k = 0; k <= 3; k++) begin
            a_in    = (k == 0) ? 4'b0010 : 4'b0000;
            a_clear = (k == 0);
            #1;
            n_cmp++;
            if (a_valid !== 4'b0000 || a_busy !== 1'b0) begin
                n_err++;
                $display("FAIL clear_trig k=%0d got v=%b b=%b exp 0000/0", k, a_valid, a_busy);
            end
            tick();
        end
        a_clear = 1'b0;
    endtask

    task automatic test_zero_len();
        a_len = 10'd0;
        for (int k = 0; k <= 4; k++) begin
            a_in = (k <= 2) ? 4'b1111 : 4'b0000;
            #1;
            n_cmp++;
            if (a_valid !== 4'b0000 || a_done !== 4'b0000 || a_busy !== 1'b0) begin
                n_err++;
                $display("FAIL zero_len k=%0d got v=%b d=%b b=%b exp 0000/0000/0", k, a_valid, a_done, a_busy);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        a_len = 10'd8;
        for (int k = 0; k <= 3; k++) begin
            a_in = (k == 0) ? 4'b1111 : 4'b0000;
            #1;
            exp4 = (k >= 1) ? 4'b1111 : 4'b0000;
            n_cmp++;
            if (a_valid !== exp4) begin
                n_err++;
                $display("FAIL pre_reset k=%0d got=%b exp=%b", k, a_valid, exp4);
            end
            if (k < 3) tick();
        end
        // Assert reset between edges: outputs must drop without a clock
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (a_valid !== 4'b0000 || a_busy !== 1'b0 || a_done !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset got v=%b b=%b d=%b exp 0000/0/0000", a_valid, a_busy, a_done);
        end
        tick();
        reset_n = 1'b1;
        tick();
        a_len = 10'd5;
        for (int k = 0; k <= 6; k++) begin
            a_in = (k == 0) ? 4'b0100 : 4'b0000;
            #1;
            exp4 = (k >= 1 && k <= 5) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (a_valid !== exp4) begin
                n_err++;
                $display("FAIL post_reset_valid k=%0d got=%b exp=%b", k, a_valid, exp4);
            end
            exp4 = (k == 5) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (a_done !== exp4) begin
                n_err++;
                $display("FAIL post_reset_done k=%0d got=%b exp=%b", k, a_done, exp4);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_retrigger();
        test_level_holdoff();
        test_edge();
        test_clear();
        test_zero_len();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
